// File: rtl/regfile_sequencer.sv
// Command-driven initiator for a 16x16 register file: WRITE, READ and CLEAR commands.
// Optional write readback check enabled by defining RF_READBACK_CHECK_EN.
module regfile_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic [1:0]        Cmd_Op,
    input  logic [ADDR_W-1:0] Cmd_Addr,
    input  logic [ADDR_W-1:0] Cmd_BAddr,
    input  logic [DATA_W-1:0] Cmd_Data,
    output logic              Wen,
    output logic [ADDR_W-1:0] WAddr,
    output logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] RAAddr,
    output logic [ADDR_W-1:0] RBAddr,
    output logic              RAen,
    output logic              RBen,
    input  logic [DATA_W-1:0] RAData,
    input  logic [DATA_W-1:0] RBData,
    output logic              Rsp_Valid,
    output logic [DATA_W-1:0] Rsp_AData,
    output logic [DATA_W-1:0] Rsp_BData,
    output logic              Chk_Err,
    output logic [2:0]        Dbg_State
);
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_RESP, S_CLEAR, S_CHECK
    } state_t;

    state_t state, nxt_state;
    logic              nxt_ready, nxt_wen, nxt_raen, nxt_rben, nxt_rsp_valid;
    logic [ADDR_W-1:0] nxt_waddr, nxt_raaddr, nxt_rbaddr, clr_cnt, nxt_clr_cnt;
    logic [DATA_W-1:0] nxt_wdata, nxt_rsp_a, nxt_rsp_b;
`ifdef RF_READBACK_CHECK_EN
    logic clr_mode, nxt_clr_mode, nxt_chk_err;
`endif

    assign Dbg_State = state;

    // Handshake: a command transfers on a rising edge where Cmd_Valid and Cmd_Ready are
    // both high; Cmd_Ready is high only in IDLE and commands offered while busy are not held.
    always_comb begin
        nxt_state     = state;
        nxt_ready     = 1'b0;
        nxt_wen       = 1'b0;
        nxt_raen      = 1'b0;
        nxt_rben      = 1'b0;
        nxt_rsp_valid = 1'b0;
        nxt_waddr     = WAddr;
        nxt_wdata     = WData;
        nxt_raaddr    = RAAddr;
        nxt_rbaddr    = RBAddr;
        nxt_rsp_a     = Rsp_AData;
        nxt_rsp_b     = Rsp_BData;
        nxt_clr_cnt   = clr_cnt;
`ifdef RF_READBACK_CHECK_EN
        nxt_clr_mode  = clr_mode;
        nxt_chk_err   = Chk_Err;
`endif
        case (state)
            S_IDLE: begin
                nxt_ready = 1'b1;
                if (Cmd_Valid) begin
                    case (Cmd_Op)
                        OP_WRITE: begin
                            nxt_state = S_WRITE;
                            nxt_ready = 1'b0;
                            nxt_wen   = 1'b1;
                            nxt_waddr = Cmd_Addr;
                            nxt_wdata = Cmd_Data;
`ifdef RF_READBACK_CHECK_EN
                            nxt_clr_mode = 1'b0;
`endif
                        end
                        OP_READ: begin
                            nxt_state  = S_READ;
                            nxt_ready  = 1'b0;
                            nxt_raen   = 1'b1;
                            nxt_rben   = 1'b1;
                            nxt_raaddr = Cmd_Addr;
                            nxt_rbaddr = Cmd_BAddr;
                        end
                        OP_CLEAR: begin
                            nxt_state   = S_CLEAR;
                            nxt_ready   = 1'b0;
                            nxt_wen     = 1'b1;
                            nxt_waddr   = '0;
                            nxt_wdata   = '0;
                            nxt_clr_cnt = '0;
`ifdef RF_READBACK_CHECK_EN
                            nxt_clr_mode = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            S_READ: begin
                nxt_state     = S_RESP;
                nxt_rsp_valid = 1'b1;
                nxt_rsp_a     = RAData;
                nxt_rsp_b     = RBData;
            end
            S_RESP: begin
                nxt_state = S_IDLE;
                nxt_ready = 1'b1;
            end
`ifdef RF_READBACK_CHECK_EN
            S_WRITE, S_CLEAR: begin
                nxt_state  = S_CHECK;
                nxt_raen   = 1'b1;
                nxt_raaddr = WAddr;
            end
            S_CHECK: begin
                if (RAData != WData) nxt_chk_err = 1'b1;
                if (clr_mode && clr_cnt != LAST_ADDR) begin
                    nxt_state   = S_CLEAR;
                    nxt_wen     = 1'b1;
                    nxt_clr_cnt = clr_cnt + ADDR_W'(1);
                    nxt_waddr   = clr_cnt + ADDR_W'(1);
                end else begin
                    nxt_state = S_IDLE;
                    nxt_ready = 1'b1;
                end
            end
`else
            S_WRITE: begin
                nxt_state = S_IDLE;
                nxt_ready = 1'b1;
            end
            S_CLEAR: begin
                // Counter holds at the last address rather than wrapping.
                if (clr_cnt == LAST_ADDR) begin
                    nxt_state = S_IDLE;
                    nxt_ready = 1'b1;
                end else begin
                    nxt_wen     = 1'b1;
                    nxt_clr_cnt = clr_cnt + ADDR_W'(1);
                    nxt_waddr   = clr_cnt + ADDR_W'(1);
                end
            end
`endif
            default: begin
                nxt_state = S_IDLE;
                nxt_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            Cmd_Ready <= 1'b1;
            Wen       <= 1'b0;
            RAen      <= 1'b0;
            RBen      <= 1'b0;
            Rsp_Valid <= 1'b0;
            WAddr     <= '0;
            WData     <= '0;
            RAAddr    <= '0;
            RBAddr    <= '0;
            Rsp_AData <= '0;
            Rsp_BData <= '0;
            clr_cnt   <= '0;
        end else begin
            state     <= nxt_state;
            Cmd_Ready <= nxt_ready;
            Wen       <= nxt_wen;
            RAen      <= nxt_raen;
            RBen      <= nxt_rben;
            Rsp_Valid <= nxt_rsp_valid;
            WAddr     <= nxt_waddr;
            WData     <= nxt_wdata;
            RAAddr    <= nxt_raaddr;
            RBAddr    <= nxt_rbaddr;
            Rsp_AData <= nxt_rsp_a;
            Rsp_BData <= nxt_rsp_b;
            clr_cnt   <= nxt_clr_cnt;
        end
    end

`ifdef RF_READBACK_CHECK_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            clr_mode <= 1'b0;
            Chk_Err  <= 1'b0;
        end else begin
            clr_mode <= nxt_clr_mode;
            Chk_Err  <= nxt_chk_err;
        end
    end
`else
    assign Chk_Err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file and a response scoreboard.
module tb_regfile_sequencer;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam logic [1:0] OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_CLEAR = 2'b11;
`ifdef RF_READBACK_CHECK_EN
    localparam int CHK_ON = 1;
`else
    localparam int CHK_ON = 0;
`endif

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Cmd_Valid = 1'b0;
    logic [1:0]        Cmd_Op = OP_NOP;
    logic [ADDR_W-1:0] Cmd_Addr = '0;
    logic [ADDR_W-1:0] Cmd_BAddr = '0;
    logic [DATA_W-1:0] Cmd_Data = '0;
    logic              Cmd_Ready, Wen, RAen, RBen, Rsp_Valid, Chk_Err;
    logic [ADDR_W-1:0] WAddr, RAAddr, RBAddr;
    logic [DATA_W-1:0] WData, RAData, RBData, Rsp_AData, Rsp_BData;
    logic [2:0]        Dbg_State;

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] ref_mem [NUM_REGS];
    logic              stuck_en = 1'b0;

    int checks = 0;
    int failures = 0;
    int wen_cycles = 0;
    int busy_cycles = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int reads_issued = 0;
    logic [ADDR_W-1:0] wen_addrs[$];
    logic [2*DATA_W-1:0] exp_q[$];

    regfile_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .Clk(Clk), .Rst(Rst), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
        .Cmd_Op(Cmd_Op), .Cmd_Addr(Cmd_Addr), .Cmd_BAddr(Cmd_BAddr), .Cmd_Data(Cmd_Data),
        .Wen(Wen), .WAddr(WAddr), .WData(WData), .RAAddr(RAAddr), .RBAddr(RBAddr),
        .RAen(RAen), .RBen(RBen), .RAData(RAData), .RBData(RBData),
        .Rsp_Valid(Rsp_Valid), .Rsp_AData(Rsp_AData), .Rsp_BData(Rsp_BData),
        .Chk_Err(Chk_Err), .Dbg_State(Dbg_State)
    );

    // Clock / environment
    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Wen) rf[WAddr] <= WData;
    assign RAData = stuck_en ? 16'hBAD0 : (RAen ? rf[RAAddr] : '0);
    assign RBData = RBen ? rf[RBAddr] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitors
    always @(posedge Clk) if (!Rst && Cmd_Valid && Cmd_Ready) acc_cnt++;

    always @(negedge Clk) begin
        if (!Rst && !Cmd_Ready) busy_cycles++;
        if (!Rst && Wen) begin
            wen_cycles++;
            wen_addrs.push_back(WAddr);
            check("wen_ready_low", 32'(Cmd_Ready), 0);
            check("wen_no_read", 32'(RAen | RBen), 0);
        end
    end

    // Scoreboard
    always @(negedge Clk) begin
        if (!Rst && Rsp_Valid) begin
            rsp_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL rsp_unexpected observed=0x%0h expected=none", {Rsp_AData, Rsp_BData});
            end
            if (exp_q.size() > 0) check("rsp_data", {Rsp_AData, Rsp_BData}, exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W-1:0] b, input logic [DATA_W-1:0] d);
        int n;
        @(negedge Clk);
        Cmd_Op = op; Cmd_Addr = a; Cmd_BAddr = b; Cmd_Data = d; Cmd_Valid = 1'b1;
        wen_cycles = 0; busy_cycles = 0; wen_addrs.delete();
        n = 0;
        while (!Cmd_Ready && n < 200) begin @(negedge Clk); n++; end
        check("accept_ready", 32'(Cmd_Ready), 1);
        if (!Cmd_Ready) begin Cmd_Valid = 1'b0; return; end
        @(posedge Clk);
        #1 Cmd_Valid = 1'b0; Cmd_Op = OP_NOP;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge Clk); n++; end while (!Cmd_Ready && n < 200);
        check("idle_reached", 32'(Cmd_Ready), 1);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ref_mem[a] = d;
        send_cmd(OP_WRITE, a, '0, d);
        wait_idle();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        exp_q.push_back({ref_mem[a], ref_mem[b]});
        reads_issued++;
        send_cmd(OP_READ, a, b, '0);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < NUM_REGS; i++) begin rf[i] = '0; ref_mem[i] = '0; end

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_ready", 32'(Cmd_Ready), 1);
        check("rst_enables", {29'd0, Wen, RAen, RBen}, 0);
        check("rst_rsp_valid", 32'(Rsp_Valid), 0);
        check("rst_rsp_data", {Rsp_AData, Rsp_BData}, 0);
        check("rst_addr_data", {8'd0, WAddr, RAAddr, RBAddr, 4'd0} | 32'(WData), 0);
        check("rst_chk_err", 32'(Chk_Err), 0);
        Rst = 1'b0;

        // 1: reset in the middle of CLEAR
        send_cmd(OP_CLEAR, '0, '0, '0);
        n = 0;
        while (!(Wen && WAddr == 4'd5) && n < 100) begin @(negedge Clk); n++; end
        check("clr_addr5_seen", {27'd0, Wen, WAddr}, {27'd0, 1'b1, 4'd5});
        #2 Rst = 1'b1;
        #1;
        check("midclr_rst_wen", 32'(Wen), 0);
        check("midclr_rst_ready", 32'(Cmd_Ready), 1);
        @(negedge Clk) Rst = 1'b0;

        // 2: single write then read
        do_write(4'd3, 16'h0013);
        check("wr_wen_cycles", wen_cycles, 1);
        if (wen_addrs.size() > 0) check("wr_waddr", 32'(wen_addrs[0]), 3);
        check("wr_busy_cycles", busy_cycles, 1 + CHK_ON);
        do_read(4'd3, 4'd11);
        check("rd_busy_cycles", busy_cycles, 2);
        repeat (3) @(negedge Clk);
        check("rsp_hold", 32'(Rsp_AData), 32'h13);

        // 3: fill all registers, read crossed pairs
        for (int i = 0; i < NUM_REGS; i++) do_write(ADDR_W'(i), DATA_W'(16'h10 + i));
        for (int i = 0; i < NUM_REGS; i++) do_read(ADDR_W'(i), ADDR_W'((i + 8) % NUM_REGS));
        check("no_false_chk_err", 32'(Chk_Err), 0);

        // 4: CLEAR sweep
        send_cmd(OP_CLEAR, '0, '0, '0);
        wait_idle();
        for (int i = 0; i < NUM_REGS; i++) ref_mem[i] = '0;
        check("clr_wen_cycles", wen_cycles, NUM_REGS);
        check("clr_busy_cycles", busy_cycles, NUM_REGS * (1 + CHK_ON));
        for (int i = 0; i < wen_addrs.size(); i++) check("clr_waddr_seq", 32'(wen_addrs[i]), i);
        do_read(4'd0, 4'd15);

        // NOP is consumed without leaving IDLE
        acc_cnt = 0;
        send_cmd(OP_NOP, '0, '0, '0);
        check("nop_ready", 32'(Cmd_Ready), 1);
        check("nop_accepted", acc_cnt, 1);

        // 5: WRITE held while READ busy
        acc_cnt = 0;
        exp_q.push_back({ref_mem[5], ref_mem[9]});
        reads_issued++;
        send_cmd(OP_READ, 4'd5, 4'd9, '0);
        Cmd_Op = OP_WRITE; Cmd_Addr = 4'd7; Cmd_Data = 16'h0077; Cmd_Valid = 1'b1;
        ref_mem[7] = 16'h0077;
        wen_cycles = 0; wen_addrs.delete();
        n = 0;
        do begin @(negedge Clk); n++; end while (!Cmd_Ready && n < 200);
        check("held_wr_ready", 32'(Cmd_Ready), 1);
        @(posedge Clk);
        #1 Cmd_Valid = 1'b0; Cmd_Op = OP_NOP;
        wait_idle();
        check("held_accepts", acc_cnt, 2);
        check("held_wen_cycles", wen_cycles, 1);
        if (wen_addrs.size() > 0) check("held_waddr", 32'(wen_addrs[0]), 7);
        do_read(4'd7, 4'd7);

        // 6: stuck readback data
        stuck_en = 1'b1;
        do_write(4'd2, 16'h1234);
        stuck_en = 1'b0;
        check("chk_err_set", 32'(Chk_Err), CHK_ON);
        do_write(4'd4, 16'h0044);
        check("chk_err_sticky", 32'(Chk_Err), CHK_ON);
        do_read(4'd2, 4'd4);
        @(negedge Clk) Rst = 1'b1;
        @(negedge Clk);
        check("chk_err_rst", 32'(Chk_Err), 0);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        check("rsp_count", rsp_cnt, reads_issued);
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
